// File: rtl/fitness_pkg.sv
// Shared definitions for the fitness session controller.
//   - activity encodings (ACT_NONE/RUN/WALK/CYCLE), matching the act_sel port
//   - MET multipliers per activity (5/8/10)
//   - controller state encoding
//   - datapath widths (SEC_W, CAL_W, WM_W)
//   - met_weight(): MET x weight as a 12-bit product
package fitness_pkg;

  localparam int SEC_W = 8;
  localparam int CAL_W = 24;
  localparam int WM_W  = 12;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_RUN   = 2'b01;
  localparam logic [1:0] ACT_WALK  = 2'b10;
  localparam logic [1:0] ACT_CYCLE = 2'b11;

  localparam logic [3:0] MET_RUN   = 4'd5;
  localparam logic [3:0] MET_WALK  = 4'd8;
  localparam logic [3:0] MET_CYCLE = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_PAUSED = 3'd2,
    ST_CALC   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Constant multipliers; each reduces to shift-adds:
  // 5w=(w<<2)+w, 8w=w<<3, 10w=(w<<3)+(w<<1). Max 10*255=2550 fits 12 bits.
  function automatic logic [WM_W-1:0] met_weight(input logic [1:0] act,
                                                 input logic [7:0] w);
    logic [WM_W-1:0] wx;
    wx = {4'b0000, w};
    case (act)
      ACT_RUN:   return wx * WM_W'(MET_RUN);
      ACT_WALK:  return wx * WM_W'(MET_WALK);
      ACT_CYCLE: return wx * WM_W'(MET_CYCLE);
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/fitness_seq_mult.sv
// 12x8 sequential shift-add multiplier used for calories = (MET*weight)*seconds.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse: capture wm/sec and run the first iteration
//   wm [11:0]     multiplicand (MET * weight)
//   sec [7:0]     multiplier (elapsed seconds), consumed LSB first
//   done          one-cycle pulse on the cycle after the 8th iteration
//   product[23:0] accumulator; final once done is seen, held until next start
// Handshake: start is a fire-and-forget pulse (no ready); the caller must not
// pulse start again until done has been seen. A new start restarts cleanly.
module fitness_seq_mult
  import fitness_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WM_W-1:0]  wm,
  input  logic [SEC_W-1:0] sec,
  output logic             done,
  output logic [CAL_W-1:0] product
);

  logic [CAL_W-1:0] acc_q;
  logic [CAL_W-1:0] mcand_q;
  logic [SEC_W-1:0] mplier_q;
  logic [2:0]       left_q;   // iterations still to run after the start edge

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      left_q   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // The start edge doubles as iteration 0 (bit 0 of sec).
        acc_q    <= sec[0] ? CAL_W'(wm) : '0;
        mcand_q  <= CAL_W'(wm) << 1;
        mplier_q <= sec >> 1;
        left_q   <= 3'd7;
      end else if (left_q != 3'd0) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        left_q   <= left_q - 3'd1;
        if (left_q == 3'd1) done <= 1'b1;
      end
    end
  end

  assign product = acc_q;

endmodule

// File: rtl/fitness_session_ctrl.sv
// Fitness tracker session controller: arbitrates Run/Walk/Cycle buttons,
// times the current activity with a prescaled one-second tick, supports
// pause/resume, and sequences fitness_seq_mult to compute
// calories = MET * weight * seconds when an activity ends.
// Optional feature macro: AUTO_STOP_EN -- when defined, the tick that brings
// seconds to SEC_MAX ends the activity as if stop were pressed.
// Parameters: CLK_PER_SEC (clocks per second tick, >=1), SEC_MAX (<=255).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   Run, Walk, Cycle   button pulses (priority Run > Walk > Cycle)
//   stop               end-activity pulse
//   weight [7:0]       user weight in kg, captured on entry to CALC
//   act_sel [1:0]      current activity (00 none, 01 Run, 10 Walk, 11 Cycle)
//   active, paused     timing running / activity paused
//   seconds [7:0]      elapsed seconds of current activity
//   calories [23:0]    last computed calories, held until next result
//   cal_valid          one-cycle pulse when calories updates
//   busy               high while computing (CALC/DONE)
module fitness_session_ctrl
  import fitness_pkg::*;
#(
  parameter int CLK_PER_SEC = 4,
  parameter int SEC_MAX     = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Run,
  input  logic             Walk,
  input  logic             Cycle,
  input  logic             stop,
  input  logic [7:0]       weight,
  output logic [1:0]       act_sel,
  output logic             active,
  output logic             paused,
  output logic [SEC_W-1:0] seconds,
  output logic [CAL_W-1:0] calories,
  output logic             cal_valid,
  output logic             busy
);

  localparam int PRE_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_LIM  = SEC_W'(SEC_MAX);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] presc_q;
  logic [1:0]       pend_q;
  logic [2:0]       calc_cnt_q;
  logic [WM_W-1:0]  wm_q;
  logic [1:0]       btn_act;
  logic             own_btn;
  logic             tick;
  logic             set_pend;
  logic             calc_entry;
  logic             mult_start;
  logic             mult_done;
  logic [CAL_W-1:0] product;

  // Button arbitration and per-state decisions.
  always_comb begin
    btn_act = Run  ? ACT_RUN  :
              Walk ? ACT_WALK :
              Cycle ? ACT_CYCLE : ACT_NONE;

    case (act_sel)
      ACT_RUN:   own_btn = Run;
      ACT_WALK:  own_btn = Walk;
      ACT_CYCLE: own_btn = Cycle;
      default:   own_btn = 1'b0;
    endcase

    tick     = (state_q == ST_ACTIVE) && (presc_q == PRE_LAST);
    state_d  = state_q;
    set_pend = 1'b0;

    case (state_q)
      ST_IDLE: if (btn_act != ACT_NONE) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (stop) state_d = ST_CALC;
`ifdef AUTO_STOP_EN
        else if (tick && seconds == SEC_LIM - SEC_W'(1)) state_d = ST_CALC;
`endif
        else if (btn_act != ACT_NONE) begin
          if (btn_act == act_sel) state_d = ST_PAUSED;
          else begin
            state_d  = ST_CALC;
            set_pend = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (stop)         state_d = ST_CALC;
        else if (own_btn) state_d = ST_ACTIVE;
      end
      ST_CALC: if (calc_cnt_q == 3'd7) state_d = ST_DONE;
      ST_DONE: state_d = (pend_q != ACT_NONE) ? ST_ACTIVE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    calc_entry = (state_d == ST_CALC) && (state_q != ST_CALC);
    // The multiplier starts on the first CALC cycle, when seconds already
    // holds its final value (a tick on the exit edge has been applied).
    mult_start = (state_q == ST_CALC) && (calc_cnt_q == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      act_sel    <= ACT_NONE;
      pend_q     <= ACT_NONE;
      presc_q    <= '0;
      seconds    <= '0;
      calories   <= '0;
      cal_valid  <= 1'b0;
      calc_cnt_q <= '0;
      wm_q       <= '0;
    end else begin
      state_q   <= state_d;
      cal_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (btn_act != ACT_NONE) begin
            act_sel <= btn_act;
            seconds <= '0;
            presc_q <= '0;
          end
        end
        ST_ACTIVE: begin
          presc_q <= tick ? '0 : presc_q + PRE_W'(1);
          if (tick && seconds != SEC_LIM) seconds <= seconds + SEC_W'(1);
          if (set_pend) pend_q <= btn_act;
        end
        ST_CALC: calc_cnt_q <= calc_cnt_q + 3'd1;
        ST_DONE: begin
          if (mult_done) begin
            calories  <= product;
            cal_valid <= 1'b1;
          end
          // Switch: go straight into the pending activity with a fresh timer.
          act_sel <= pend_q;
          pend_q  <= ACT_NONE;
          if (pend_q != ACT_NONE) begin
            seconds <= '0;
            presc_q <= '0;
          end
        end
        default: ;
      endcase
      if (calc_entry) begin
        wm_q       <= met_weight(act_sel, weight);
        calc_cnt_q <= '0;
      end
    end
  end

  fitness_seq_mult u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .wm      (wm_q),
    .sec     (seconds),
    .done    (mult_done),
    .product (product)
  );

  assign active = (state_q == ST_ACTIVE);
  assign paused = (state_q == ST_PAUSED);
  assign busy   = (state_q == ST_CALC) || (state_q == ST_DONE);

endmodule

// File: tb/tb_fitness_session_ctrl.sv
// Bench for fitness_session_ctrl: directed scenarios plus random stimulus,
// a cycle-count reference model, and a scoreboard monitor.
module tb_fitness_session_ctrl;

  localparam int CPS  = 4;
  localparam int SMAX = 255;
`ifdef AUTO_STOP_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ctl vector: {rst, stop, Cycle, Walk, Run}
  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_RUN  = 5'b00001;
  localparam logic [4:0] B_WALK = 5'b00010;
  localparam logic [4:0] B_CYC  = 5'b00100;
  localparam logic [4:0] B_STOP = 5'b01000;
  localparam logic [4:0] B_RST  = 5'b10000;

  logic        clk;
  logic        rst, Run, Walk, Cycle, stop;
  logic [7:0]  weight;
  logic [1:0]  act_sel;
  logic        active, paused, cal_valid, busy;
  logic [7:0]  seconds;
  logic [23:0] calories;

  fitness_session_ctrl #(.CLK_PER_SEC(CPS), .SEC_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .Run(Run), .Walk(Walk), .Cycle(Cycle), .stop(stop),
    .weight(weight), .act_sel(act_sel), .active(active), .paused(paused),
    .seconds(seconds), .calories(calories), .cal_valid(cal_valid), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [23:0] exp_q[$];   // expected calories, pushed when a calc starts
  logic [37:0] st_q[$];    // expected per-cycle output snapshot
  logic [7:0]  cur_w;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 timing, 2 paused, 3 computing
  int m_mode, m_act, m_pend, m_cycles, m_left;
  logic [23:0] m_cal, m_res;
  logic        m_valid;

  function automatic int prio(input logic [4:0] ctl);
    if (ctl[0]) return 1;
    if (ctl[1]) return 2;
    if (ctl[2]) return 3;
    return 0;
  endfunction

  function automatic int met(input int a);
    case (a)
      1: return 5;
      2: return 8;
      3: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int msec(input int cyc);
    return (cyc / CPS > SMAX) ? SMAX : cyc / CPS;
  endfunction

  task automatic start_calc(input int wt);
    m_mode = 3;
    m_left = 9;
    m_res  = 24'(met(m_act) * wt * msec(m_cycles));
    exp_q.push_back(m_res);
  endtask

  task automatic model_reset();
    m_mode = 0; m_act = 0; m_pend = 0; m_cycles = 0; m_left = 0;
    m_cal = '0; m_res = '0; m_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [4:0] ctl, input int wt);
    int  b;
    bit  own;
    b   = prio(ctl);
    own = (m_act == 1 && ctl[0]) || (m_act == 2 && ctl[1]) || (m_act == 3 && ctl[2]);
    m_valid = 1'b0;
    if (ctl[4]) model_reset();
    else begin
      case (m_mode)
        0: if (b != 0) begin m_act = b; m_cycles = 0; m_mode = 1; end
        1: begin
          m_cycles++;
          if (ctl[3]) start_calc(wt);
          else if (AUTO && msec(m_cycles - 1) < SMAX && msec(m_cycles) == SMAX) start_calc(wt);
          else if (b != 0 && b == m_act) m_mode = 2;
          else if (b != 0) begin m_pend = b; start_calc(wt); end
        end
        2: begin
          if (ctl[3]) start_calc(wt);
          else if (own) m_mode = 1;
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_cal   = m_res;
            m_valid = 1'b1;
            if (m_pend != 0) begin
              m_act = m_pend; m_pend = 0; m_cycles = 0; m_mode = 1;
            end else begin
              m_act = 0; m_mode = 0;
            end
          end
        end
      endcase
    end
    st_q.push_back({2'(m_act), m_mode == 1, m_mode == 2, m_mode == 3, m_valid,
                    8'(msec(m_cycles)), m_cal});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [4:0] ctl);
    Run = ctl[0]; Walk = ctl[1]; Cycle = ctl[2]; stop = ctl[3]; rst = ctl[4];
    weight = cur_w;
    @(posedge clk);
    model_step(ctl, int'(cur_w));
    #1;
    Run = 1'b0; Walk = 1'b0; Cycle = 1'b0; stop = 1'b0; rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(B_NONE);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [37:0] mon_exp, mon_got;
  logic [23:0] mon_cal;
  always @(negedge clk) begin
    if (st_q.size() > 0) begin
      mon_exp = st_q.pop_front();
      mon_got = {act_sel, active, paused, busy, cal_valid, seconds, calories};
      tests++;
      if (mon_got !== mon_exp) begin
        fails++;
        $display("FAIL status got=%h exp=%h (act,act,pau,busy,val,sec,cal) t=%0t",
                 mon_got, mon_exp, $time);
      end
      if (cal_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL cal_unexpected got=%0d exp=none", calories);
        end else begin
          mon_cal = exp_q.pop_front();
          if (calories !== mon_cal) begin
            fails++;
            $display("FAIL cal_value got=%0d exp=%0d", calories, mon_cal);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    Run = 1'b0; Walk = 1'b0; Cycle = 1'b0; stop = 1'b0; rst = 1'b1;
    weight = '0; cur_w = '0;
    model_reset();

    // Reset state
    step(B_RST);
    @(negedge clk);
    chk("reset_act_sel", act_sel, 0);
    chk("reset_seconds", seconds, 0);
    chk("reset_calories", calories, 0);
    chk("reset_flags", {active, paused, busy, cal_valid}, 0);

    // Basic: Run, 40 cycles, stop -> 10 s, 3500 kcal, result 9 cycles later
    cur_w = 8'd70;
    step(B_RUN);
    idle(40);
    step(B_STOP);
    idle(9);
    @(negedge clk);
    chk("basic_cal_valid", cal_valid, 1);
    chk("basic_calories", calories, 3500);
    chk("basic_seconds", seconds, 10);
    chk("basic_act_idle", act_sel, 0);
    idle(2);

    // Priority: Walk + Cycle in idle -> Walk
    step(B_WALK | B_CYC);
    @(negedge clk);
    chk("prio_walk", act_sel, 2);
    step(B_STOP);
    idle(10);

    // Pause / resume
    cur_w = 8'd60;
    step(B_RUN);
    idle(8);
    step(B_RUN);
    idle(20);
    @(negedge clk);
    chk("pause_flag", paused, 1);
    chk("pause_seconds_held", seconds, 2);
    step(B_RUN);
    idle(4);
    step(B_STOP);
    idle(9);
    @(negedge clk);
    chk("pause_calories", calories, 900);
    chk("pause_seconds", seconds, 3);
    idle(2);

    // Switch Cycle -> Walk; buttons during CALC ignored
    cur_w = 8'd50;
    step(B_CYC);
    idle(12);
    step(B_WALK);
    for (int i = 0; i < 8; i++)
      step({1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7))});
    step(B_NONE);
    @(negedge clk);
    chk("switch_cal_valid", cal_valid, 1);
    chk("switch_calories", calories, 1500);
    chk("switch_act_sel", act_sel, 2);
    chk("switch_seconds", seconds, 0);
    chk("switch_active", active, 1);
    step(B_STOP);
    idle(10);

    // Saturation
    cur_w = 8'd255;
    step(B_WALK);
    idle(1100);
    @(negedge clk);
    if (AUTO) begin
      chk("sat_auto_idle", active, 0);
      chk("sat_auto_calories", calories, 520200);
    end else begin
      chk("sat_seconds", seconds, 255);
      chk("sat_still_active", active, 1);
      step(B_STOP);
      idle(9);
      @(negedge clk);
      chk("sat_calories", calories, 520200);
    end
    idle(2);

    // Reset in the 4th CALC cycle aborts the computation
    cur_w = 8'd40;
    step(B_RUN);
    idle(8);
    step(B_STOP);
    idle(3);
    step(B_RST);
    @(negedge clk);
    chk("rst_calc_act", act_sel, 0);
    chk("rst_calc_seconds", seconds, 0);
    chk("rst_calc_calories", calories, 0);
    chk("rst_calc_flags", {active, paused, busy, cal_valid}, 0);
    idle(12);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cur_w = 8'($urandom_range(0, 255));
      step({($urandom_range(0, 799) == 0), ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 19) == 0)});
    end

    // Drain: end any activity and let its result come out
    step(B_STOP);
    idle(12);
    @(negedge clk);
    @(negedge clk);
    chk("drain_cal_queue", exp_q.size(), 0);
    chk("drain_status_queue", st_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
